// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - phase codes, lamp encodings and BCD helpers for the traffic phase scheduler
package tl_pkg;

    typedef enum logic [2:0] {
        PH_NS_G,
        PH_NS_Y,
        PH_CLR,
        PH_EW_G,
        PH_EW_Y
    } phase_e;

    localparam logic [7:0] CODE_NS_G = 8'h00;
    localparam logic [7:0] CODE_NS_Y = 8'h01;
    localparam logic [7:0] CODE_CLR  = 8'hAA;
    localparam logic [7:0] CODE_EW_G = 8'h11;
    localparam logic [7:0] CODE_EW_Y = 8'h10;
    localparam logic [7:0] CODE_HOLD = 8'hEE;

    // {ew_r, ew_y, ew_g, ns_r, ns_y, ns_g}
    localparam logic [5:0] LAMP_NS_G = 6'b100_001;
    localparam logic [5:0] LAMP_NS_Y = 6'b100_010;
    localparam logic [5:0] LAMP_CLR  = 6'b100_100;
    localparam logic [5:0] LAMP_EW_G = 6'b001_100;
    localparam logic [5:0] LAMP_EW_Y = 6'b010_100;

    function automatic logic [7:0] phase_code(input phase_e p);
        case (p)
            PH_NS_G: phase_code = CODE_NS_G;
            PH_NS_Y: phase_code = CODE_NS_Y;
            PH_EW_G: phase_code = CODE_EW_G;
            PH_EW_Y: phase_code = CODE_EW_Y;
            default: phase_code = CODE_CLR;
        endcase
    endfunction

    function automatic logic [5:0] phase_lamp(input phase_e p);
        case (p)
            PH_NS_G: phase_lamp = LAMP_NS_G;
            PH_NS_Y: phase_lamp = LAMP_NS_Y;
            PH_EW_G: phase_lamp = LAMP_EW_G;
            PH_EW_Y: phase_lamp = LAMP_EW_Y;
            default: phase_lamp = LAMP_CLR;
        endcase
    endfunction

    // Two-digit BCD decrement that saturates at 00.
    function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
        if (v == 8'h00) begin
            bcd_dec8 = 8'h00;
        end else if (v[3:0] == 4'd0) begin
            bcd_dec8 = {v[7:4] - 4'd1, 4'd9};
        end else begin
            bcd_dec8 = {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    function automatic logic [7:0] to_bcd8(input int unsigned n);
        to_bcd8 = {4'(n / 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/tl_bcd_down.sv
// rtl/tl_bcd_down.sv - two-digit BCD down-counter with load, hold, decrement enable and zero flag
module tl_bcd_down
    import tl_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       hold_i,
    input  logic       dec_i,
    output logic [7:0] count_o,
    output logic [7:0] count_d_o,
    output logic       zero_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && !hold_i) begin
            count_d = bcd_dec8(count_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;
    assign zero_o    = (count_q == 8'h00);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - NS/EW phase sequencer with pedestrian cut and emergency preempt
// Optional feature macro: TL_PED_EN (pedestrian latches and green truncation).
module traffic_phase_scheduler
    import tl_pkg::*;
#(
    parameter int unsigned GREEN_S   = 9,
    parameter int unsigned YELLOW_S  = 4,
    parameter int unsigned CLEAR_S   = 1,
    parameter int unsigned PED_CUT_S = 3
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        ped_req_ns,
    input  logic        ped_req_ew,
    input  logic        emerg_req,
    input  logic        emerg_dir,
    output logic [5:0]  light,
    output logic        flash_en,
    output logic [15:0] total_state
);

    localparam logic [7:0] GREEN_BCD  = to_bcd8(GREEN_S - 1);
    localparam logic [7:0] YELLOW_BCD = to_bcd8(YELLOW_S - 1);
    localparam logic [7:0] CLEAR_BCD  = to_bcd8(CLEAR_S - 1);
    localparam logic [7:0] CUT_BCD    = to_bcd8(PED_CUT_S - 1);

    phase_e      phase_q, phase_d;
    logic        next_dir_q, next_dir_d;
    logic        hold_q, hold_d;
    logic        cnt_load, cnt_dec;
    logic [7:0]  cnt_load_val;
    logic [7:0]  cnt_q, cnt_d;
    logic        cnt_zero;
    logic        in_green, green_dir;
    logic        ped_hit, ped_cut;
    logic [5:0]  light_d;
    logic        flash_d;
    logic [15:0] total_d;

    tl_bcd_down #(
        .RESET_VAL (CLEAR_BCD)
    ) u_cnt (
        .clk_i      (clk_50MHz),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .hold_i     (hold_d),
        .dec_i      (cnt_dec),
        .count_o    (cnt_q),
        .count_d_o  (cnt_d),
        .zero_o     (cnt_zero)
    );

    assign in_green  = (phase_q == PH_NS_G) || (phase_q == PH_EW_G);
    assign green_dir = (phase_q == PH_EW_G);
    assign ped_cut   = ped_hit && (cnt_q > CUT_BCD);

`ifdef TL_PED_EN
    logic ped_ns_q, ped_ns_d;
    logic ped_ew_q, ped_ew_d;
    logic ns_entry, ew_entry;

    assign ns_entry = tick_1hz && (phase_d == PH_NS_G) && (phase_q != PH_NS_G);
    assign ew_entry = tick_1hz && (phase_d == PH_EW_G) && (phase_q != PH_EW_G);
    // A press on the entry cycle itself survives, so it serves the next cycle.
    assign ped_ns_d = (ped_ns_q && !ns_entry) || ped_req_ns;
    assign ped_ew_d = (ped_ew_q && !ew_entry) || ped_req_ew;
    assign ped_hit  = ((phase_q == PH_EW_G) && ped_ns_q) || ((phase_q == PH_NS_G) && ped_ew_q);

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            ped_ns_q <= 1'b0;
            ped_ew_q <= 1'b0;
        end else begin
            ped_ns_q <= ped_ns_d;
            ped_ew_q <= ped_ew_d;
        end
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req_ns ^ ped_req_ew;
    assign ped_hit    = 1'b0;
`endif

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            phase_q     <= PH_CLR;
            next_dir_q  <= 1'b0;
            hold_q      <= 1'b0;
            light       <= LAMP_CLR;
            flash_en    <= 1'b0;
            total_state <= {CODE_CLR, CLEAR_BCD};
        end else begin
            phase_q     <= phase_d;
            next_dir_q  <= next_dir_d;
            hold_q      <= hold_d;
            light       <= light_d;
            flash_en    <= flash_d;
            total_state <= total_d;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        next_dir_d   = next_dir_q;
        hold_d       = hold_q;
        cnt_load     = 1'b0;
        cnt_load_val = 8'h00;
        cnt_dec      = 1'b0;
        if (tick_1hz) begin
            if (in_green) begin
                if (emerg_req && (emerg_dir == green_dir)) begin
                    hold_d = 1'b1;
                end else if (emerg_req) begin
                    hold_d       = 1'b0;
                    phase_d      = green_dir ? PH_EW_Y : PH_NS_Y;
                    cnt_load     = 1'b1;
                    cnt_load_val = YELLOW_BCD;
                end else if (hold_q) begin
                    // Release tick only unfreezes; counting resumes next tick.
                    hold_d = 1'b0;
                end else if (cnt_zero) begin
                    phase_d      = green_dir ? PH_EW_Y : PH_NS_Y;
                    cnt_load     = 1'b1;
                    cnt_load_val = YELLOW_BCD;
                end else if (ped_cut) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CUT_BCD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end else if (phase_q == PH_CLR) begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = GREEN_BCD;
                    // next_dir tracks the served green so the following CLR toggle hands over.
                    if (emerg_req) begin
                        phase_d    = emerg_dir ? PH_EW_G : PH_NS_G;
                        next_dir_d = emerg_dir;
                    end else begin
                        phase_d = next_dir_q ? PH_EW_G : PH_NS_G;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end else begin
                if (cnt_zero) begin
                    phase_d      = PH_CLR;
                    next_dir_d   = !next_dir_q;
                    cnt_load     = 1'b1;
                    cnt_load_val = CLEAR_BCD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
        end
    end

    always_comb begin
        light_d = phase_lamp(phase_d);
        flash_d = ((phase_d == PH_NS_G) || (phase_d == PH_EW_G)) && (cnt_d < 8'h03) && !hold_d;
        total_d = {phase_code(phase_d), hold_d ? CODE_HOLD : cnt_d};
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - table-driven bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

`ifdef TL_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic        clk_50MHz  = 1'b0;
    logic        reset      = 1'b1;
    logic        tick_1hz   = 1'b0;
    logic        ped_req_ns = 1'b0;
    logic        ped_req_ew = 1'b0;
    logic        emerg_req  = 1'b0;
    logic        emerg_dir  = 1'b0;
    logic [5:0]  light;
    logic        flash_en;
    logic [15:0] total_state;

    traffic_phase_scheduler dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .ped_req_ns  (ped_req_ns),
        .ped_req_ew  (ped_req_ew),
        .emerg_req   (emerg_req),
        .emerg_dir   (emerg_dir),
        .light       (light),
        .flash_en    (flash_en),
        .total_state (total_state)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic        pns;
        logic        pew;
        logic        er;
        logic        ed;
        logic [15:0] exp_total;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] lamp_of(input logic [7:0] code);
        case (code)
            8'h00:   lamp_of = 6'b100_001;
            8'h01:   lamp_of = 6'b100_010;
            8'h11:   lamp_of = 6'b001_100;
            8'h10:   lamp_of = 6'b010_100;
            default: lamp_of = 6'b100_100;
        endcase
    endfunction

    function automatic logic flash_of(input logic [15:0] t);
        flash_of = ((t[15:8] == 8'h00) || (t[15:8] == 8'h11)) && (t[7:0] < 8'h03);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic pns, input logic pew, input logic er, input logic ed,
                       input logic [15:0] e);
        vq.push_back('{pns, pew, er, ed, e});
    endtask

    // Button pulse one cycle ahead of the tick; emergency level held through the tick.
    task automatic drive_tick(input logic pns, input logic pew, input logic er, input logic ed);
        @(negedge clk_50MHz);
        emerg_req  = er;
        emerg_dir  = ed;
        ped_req_ns = pns;
        ped_req_ew = pew;
        @(negedge clk_50MHz);
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
        tick_1hz   = 1'b1;
        @(negedge clk_50MHz);
        tick_1hz   = 1'b0;
    endtask

    task automatic run(input string tag);
        foreach (vq[i]) begin
            drive_tick(vq[i].pns, vq[i].pew, vq[i].er, vq[i].ed);
            chk($sformatf("%s[%0d] total", tag, i), total_state, vq[i].exp_total);
            chk($sformatf("%s[%0d] light", tag, i), {10'd0, light}, {10'd0, lamp_of(vq[i].exp_total[15:8])});
            chk($sformatf("%s[%0d] flash", tag, i), {15'd0, flash_en}, {15'd0, flash_of(vq[i].exp_total)});
        end
        vq.delete();
    endtask

    task automatic seek(input string tag, input logic [15:0] target);
        int n;
        n = 0;
        while (total_state !== target && n < 60) begin
            drive_tick(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk({tag, " seek"}, total_state, target);
    endtask

    task automatic do_reset();
        @(negedge clk_50MHz);
        reset     = 1'b1;
        emerg_req = 1'b0;
        @(negedge clk_50MHz);
        reset = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("reset total", total_state, 16'hAA00);
        chk("reset light", {10'd0, light}, 16'h0024);
        chk("reset flash", {15'd0, flash_en}, 16'h0000);

        // Full default cycle.
        for (int k = 8; k >= 0; k--) add(0, 0, 0, 0, {8'h00, 8'(k)});
        for (int k = 3; k >= 0; k--) add(0, 0, 0, 0, {8'h01, 8'(k)});
        add(0, 0, 0, 0, 16'hAA00);
        for (int k = 8; k >= 0; k--) add(0, 0, 0, 0, {8'h11, 8'(k)});
        for (int k = 3; k >= 0; k--) add(0, 0, 0, 0, {8'h10, 8'(k)});
        add(0, 0, 0, 0, 16'hAA00);
        add(0, 0, 0, 0, 16'h0008);
        run("cycle");

        // Pedestrian cut in EW_G, latch clear on NS_G entry, cut in NS_G, press latched for next cycle.
        do_reset();
        seek("ped", 16'h1107);
        add(1, 0, 0, 0, PED ? 16'h1102 : 16'h1106);
        add(0, 0, 0, 0, PED ? 16'h1101 : 16'h1105);
        add(0, 0, 0, 0, PED ? 16'h1100 : 16'h1104);
        add(0, 0, 0, 0, PED ? 16'h1003 : 16'h1103);
        run("ped_ew_g");
        seek("ped", 16'h0008);
        seek("ped", 16'h1108);
        add(0, 0, 0, 0, 16'h1107);
        add(0, 0, 0, 0, 16'h1106);
        run("ped_clear");
        seek("ped", 16'h0007);
        add(1, 0, 0, 0, 16'h0006);
        add(0, 1, 0, 0, PED ? 16'h0002 : 16'h0005);
        add(0, 0, 0, 0, PED ? 16'h0001 : 16'h0004);
        add(0, 0, 0, 0, PED ? 16'h0000 : 16'h0003);
        add(0, 0, 0, 0, PED ? 16'h0103 : 16'h0002);
        run("ped_ns_g");
        seek("ped", 16'h1108);
        add(0, 0, 0, 0, PED ? 16'h1102 : 16'h1107);
        run("ped_next");

        // Emergency to EW from NS_G: yellow, clear, EW_G, hold, release.
        do_reset();
        seek("emg1", 16'h0005);
        add(0, 0, 1, 1, 16'h0103);
        add(0, 0, 1, 1, 16'h0102);
        add(0, 0, 1, 1, 16'h0101);
        add(0, 0, 1, 1, 16'h0100);
        add(0, 0, 1, 1, 16'hAA00);
        add(0, 0, 1, 1, 16'h1108);
        add(0, 0, 1, 1, 16'h11EE);
        add(0, 0, 1, 1, 16'h11EE);
        add(0, 0, 0, 0, 16'h1108);
        add(0, 0, 0, 0, 16'h1107);
        run("emg1");

        // Emergency overrides next_dir at CLR exit.
        do_reset();
        seek("emg2", 16'h1000);
        add(0, 0, 1, 1, 16'hAA00);
        add(0, 0, 1, 1, 16'h1108);
        add(0, 0, 1, 1, 16'h11EE);
        add(0, 0, 0, 0, 16'h1108);
        run("emg2");

        // Long hold in NS_G freezes countdown and suppresses flash.
        do_reset();
        seek("emg3", 16'h0004);
        for (int k = 0; k < 20; k++) add(0, 0, 1, 0, 16'h00EE);
        add(0, 0, 0, 0, 16'h0004);
        add(0, 0, 0, 0, 16'h0003);
        add(0, 0, 0, 0, 16'h0002);
        add(0, 0, 0, 0, 16'h0001);
        add(0, 0, 0, 0, 16'h0000);
        add(0, 0, 0, 0, 16'h0103);
        run("emg3");

        // Reset mid EW_Y with latches set, coincident with a tick.
        do_reset();
        seek("rst", 16'h1003);
        @(negedge clk_50MHz);
        ped_req_ns = 1'b1;
        ped_req_ew = 1'b1;
        @(negedge clk_50MHz);
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
        reset      = 1'b1;
        tick_1hz   = 1'b1;
        @(negedge clk_50MHz);
        reset    = 1'b0;
        tick_1hz = 1'b0;
        chk("rst total", total_state, 16'hAA00);
        chk("rst light", {10'd0, light}, 16'h0024);
        chk("rst flash", {15'd0, flash_en}, 16'h0000);
        add(0, 0, 0, 0, 16'h0008);
        add(0, 0, 0, 0, 16'h0007);
        add(0, 0, 0, 0, 16'h0006);
        run("rst_latch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
